// File: rtl/lif_pkg.sv
// Shared types and defaults for the LIF neuron scheduler.
// Imported by the update datapath and the sequencer top.
package lif_pkg;

  localparam int LIF_WIDTH = 8;
  localparam int LIF_THRESH_DEFAULT = 230;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/lif_update.sv
// Single leaky-integrate-and-fire step for one neuron.
// Leak is s*7/8 built from shifts; the sum wraps modulo 2^WIDTH.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH = LIF_WIDTH
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] next,
  output logic             spk
);

  // Fire on reaching threshold, otherwise leak and integrate.
  always_comb begin
    spk  = (s >= threshold);
    next = spk ? '0
         : c + (s >> 1) + (s >> 2) + (s >> 3);
  end

endmodule

// File: rtl/lif_scheduler.sv
// Sequences one shared LIF datapath over N_NEURONS neurons per timestep.
// Publishes the spike vector and a done pulse at the end of each sweep.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS      = 4,
  parameter int WIDTH          = LIF_WIDTH,
  parameter int THRESH_DEFAULT = LIF_THRESH_DEFAULT,
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_NEURONS*WIDTH-1:0] cur_in,
  input  logic                       thr_we,
  input  logic [WIDTH-1:0]           thr_in,
  input  logic [IW-1:0]              mon_idx,
  output logic [WIDTH-1:0]           mon_state,
  output logic [N_NEURONS-1:0]       spikes,
  output logic                       busy,
  output logic                       done
);

  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

  state_t               state_q;
  state_t               state_d;
  logic [IW-1:0]        idx_q;
  logic [WIDTH-1:0]     thr_q;
  logic [WIDTH-1:0]     st_q  [N_NEURONS];
  logic [WIDTH-1:0]     cur_q [N_NEURONS];
  logic [N_NEURONS-1:0] acc_q;
  logic [N_NEURONS-1:0] acc_d;
  logic [N_NEURONS-1:0] spikes_q;
  logic [WIDTH-1:0]     s_sel;
  logic [WIDTH-1:0]     c_sel;
  logic [WIDTH-1:0]     nxt;
  logic                 spk;
  logic                 last;

  assign s_sel  = st_q[idx_q];
  assign c_sel  = cur_q[idx_q];
  assign last   = (idx_q == LAST);
  assign spikes = spikes_q;

  lif_update #(
    .WIDTH(WIDTH)
  ) u_update (
    .s        (s_sel),
    .c        (c_sel),
    .threshold(thr_q),
    .next     (nxt),
    .spk      (spk)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus busy/done decode.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = UPDATE;
      end
      UPDATE: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Spike accumulator with the current neuron's result merged in.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = spk;
  end

  // Datapath: threshold, current latch, state array, spikes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      thr_q    <= WIDTH'(THRESH_DEFAULT);
      acc_q    <= '0;
      spikes_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        st_q[i]  <= '0;
        cur_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (thr_we) thr_q <= thr_in;
          if (start) begin
            idx_q <= '0;
            for (int i = 0; i < N_NEURONS; i++)
              cur_q[i] <= cur_in[i*WIDTH +: WIDTH];
          end
        end
        UPDATE: begin
          st_q[idx_q] <= nxt;
          acc_q       <= acc_d;
          if (last) spikes_q <= acc_d;
          else      idx_q    <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Monitor read; out-of-range indices read as zero.
  always_comb begin
    mon_state = '0;
    if (int'(mon_idx) < N_NEURONS)
      mon_state = st_q[mon_idx];
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Scoreboard bench for lif_scheduler with a behavioural LIF model.
// Stimulus pushes expected sweeps; a monitor checks them on done.
module tb_lif_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [N-1:0]   spk;
    logic [N*W-1:0] st;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N*W-1:0] cur_in;
  logic           thr_we;
  logic [W-1:0]   thr_in;
  logic [IW-1:0]  mon_idx;
  logic [W-1:0]   mon_state;
  logic [N-1:0]   spikes;
  logic           busy;
  logic           done;

  int   tests;
  int   fails;
  int   n_push;
  int   n_done;
  exp_t q[$];
  int   m_st[N];
  int   m_thr;

  lif_scheduler #(
    .N_NEURONS     (N),
    .WIDTH         (W),
    .THRESH_DEFAULT(230)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cur_in   (cur_in),
    .thr_we   (thr_we),
    .thr_in   (thr_in),
    .mon_idx  (mon_idx),
    .mon_state(mon_state),
    .spikes   (spikes),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] splat(input int v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_cur();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_st[i] = 0;
    m_thr = 230;
  endtask

  // Membrane: fire at threshold, else keep 7/8 (floored shifts) plus input.
  task automatic model_sweep(input logic [N*W-1:0] cur);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      int  s;
      int  c;
      bit  f;
      s = m_st[i];
      c = int'(cur[i*W +: W]);
      f = (s >= m_thr);
      m_st[i] = f ? 0 : (c + s / 2 + s / 4 + s / 8) % (1 << W);
      e.spk[i] = f;
      e.st[i*W +: W] = W'(m_st[i]);
    end
    q.push_back(e);
    n_push++;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    thr_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_spikes", 64'(spikes), 64'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_thr(input logic [W-1:0] v);
    @(negedge clk);
    thr_we = 1'b1;
    thr_in = v;
    @(posedge clk);
    #1;
    thr_we = 1'b0;
    m_thr  = int'(v);
  endtask

  // One timestep; optional hold of start, mid-sweep noise, same-cycle thr.
  task automatic run_step(input logic [N*W-1:0] cur,
                          input bit hold,
                          input bit mid,
                          input bit wthr,
                          input logic [W-1:0] tv);
    @(negedge clk);
    start  = 1'b1;
    cur_in = cur;
    if (wthr) begin
      thr_we = 1'b1;
      thr_in = tv;
      m_thr  = int'(tv);
    end
    model_sweep(cur);
    @(posedge clk);
    #1;
    thr_we = 1'b0;
    if (!hold) start = 1'b0;
    check("busy_c1", 64'(busy), 64'd1);
    check("done_c1", 64'(done), 64'd0);
    if (mid) begin
      thr_we = 1'b1;
      thr_in = 8'd10;
      cur_in = rand_cur();
    end
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk);
      #1;
      check("busy_seq", 64'(busy), 64'(k <= N));
      check("done_seq", 64'(done), 64'(k == N));
      thr_we = 1'b0;
    end
    start = 1'b0;
  endtask

  // Monitor: on every done, pop an expectation and compare everything.
  initial begin
    mon_idx = '0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_done++;
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("spikes", 64'(spikes), 64'(e.spk));
          for (int i = 0; i < N; i++) begin
            mon_idx = IW'(i);
            #1;
            check("state", 64'(mon_state), 64'(e.st[i*W +: W]));
          end
        end
      end
    end
  end

  initial begin
    tests  = 0;
    fails  = 0;
    n_push = 0;
    n_done = 0;
    cur_in = '0;
    thr_in = '0;
    do_reset();

    run_step(splat(100), 0, 0, 0, '0);

    do_reset();
    for (int t = 0; t < 6; t++)
      run_step({24'd0, 8'd60}, 0, 0, 0, '0);

    run_step({24'd0, 8'd60}, 0, 0, 0, '0);
    write_thr(8'd50);
    run_step({24'd0, 8'd60}, 0, 1, 0, '0);
    run_step({24'd0, 8'd60}, 0, 0, 0, '0);
    run_step({24'd0, 8'd45}, 0, 0, 0, '0);

    do_reset();
    run_step(splat(200), 0, 0, 1, 8'd255);
    run_step(splat(200), 0, 0, 0, '0);

    run_step(splat(17), 1, 0, 0, '0);
    @(posedge clk);
    #1;
    check("held_idle", 64'(busy), 64'd0);

    for (int t = 0; t < 24; t++) begin
      bit wt;
      wt = ($urandom_range(0, 3) == 0);
      run_step(rand_cur(), 1'($urandom), 1'($urandom), wt,
               W'($urandom_range(60, 255)));
    end

    run_step(splat(5), 0, 0, 1, 8'd0);
    write_thr(8'd240);
    @(negedge clk);
    start  = 1'b1;
    cur_in = splat(99);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_spikes", 64'(spikes), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < N + 3; k++) begin
      @(posedge clk);
      #1;
      check("no_done_after_abort", 64'(done), 64'd0);
    end
    run_step(splat(230), 0, 0, 0, '0);
    run_step(splat(0), 0, 0, 0, '0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(q.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(n_push));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
